// File: rtl/udp_rxbuf_drain.sv
// CPU-side drain of the UDP RX buffer: holds the buffer RAM, reads the length
// header on grant, streams the payload bytes on AXI-Stream, then releases.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for the arbiter grant
// HDR      | read of word 0 (length header) issued
// HDRW     | header on RAM output; latch clamped length, read word 1
// LOAD     | word 1 into output register, tvalid up, prefetch word 2
// STREAM   | one byte per handshake; prefetch refills at word boundaries
// REL      | one-cycle release pulse, packet counter advances
// WAITLOW  | hold off until the grant drops so one grant drains once
module udp_rxbuf_drain #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_int,
    input  logic                  rst_int,
    input  logic [ADDR_WIDTH-1:0] udp_rxbuf_addr,
    input  logic                  udp_rxbuf_ce,
    input  logic                  udp_rxbuf_we,
    input  logic [DATA_WIDTH-1:0] udp_rxbuf_d,
    input  logic                  udp_rxbuf_cpu_grant,
    output logic                  udp_rxbuf_cpu_rel,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           rx_len,
    output logic                  len_err,
    output logic [15:0]           pkt_count
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [15:0] CAP_BYTES = 16'(4 * (DEPTH - 1));

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_HDRW    = 3'd2;
    localparam logic [2:0] S_LOAD    = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;
    localparam logic [2:0] S_REL     = 3'd5;
    localparam logic [2:0] S_WAITLOW = 3'd6;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_word;
    logic [1:0]            r_lane;
    logic [15:0]           r_remain;
    logic                  r_tvalid;
    logic [15:0]           r_rx_len;
    logic                  r_len_err;
    logic [15:0]           r_pkt_count;

    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_hs;
    logic                  w_last;
    logic [15:0]           w_hdr_len;
    logic                  w_over;
    logic [15:0]           w_clamp;

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk_int) begin
        if (udp_rxbuf_ce && udp_rxbuf_we) begin
            r_mem[udp_rxbuf_addr] <= udp_rxbuf_d;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign w_hs      = r_tvalid && m_axis_tready;
    assign w_last    = r_tvalid && (r_remain == 16'd1);
    assign w_hdr_len = r_rd_data[15:0];
    assign w_over    = (w_hdr_len > CAP_BYTES);
    assign w_clamp   = w_over ? CAP_BYTES : w_hdr_len;

    // RAM output doubles as the prefetch register; it is only refreshed when
    // the current word's last byte leaves, so it holds the next word meanwhile.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_ptr;
        case (r_state)
            S_HDR: begin
                w_rd_en   = 1'b1;
                w_rd_addr = '0;
            end
            S_HDRW: begin
                w_rd_en   = 1'b1;
                w_rd_addr = ADDR_WIDTH'(1);
            end
            S_LOAD: begin
                w_rd_en   = 1'b1;
            end
            S_STREAM: begin
                w_rd_en   = w_hs && (r_lane == 2'd3) && !w_last;
            end
            default: begin
                w_rd_en   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_word      <= '0;
            r_lane      <= 2'd0;
            r_remain    <= 16'd0;
            r_tvalid    <= 1'b0;
            r_rx_len    <= 16'd0;
            r_len_err   <= 1'b0;
            r_pkt_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (udp_rxbuf_cpu_grant) begin
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    r_state <= S_HDRW;
                end
                S_HDRW: begin
                    r_rx_len <= w_clamp;
                    r_remain <= w_clamp;
                    r_rd_ptr <= ADDR_WIDTH'(2);
                    if (w_over) begin
                        r_len_err <= 1'b1;
                    end
                    r_state <= (w_clamp == 16'd0) ? S_REL : S_LOAD;
                end
                S_LOAD: begin
                    r_word   <= r_rd_data;
                    r_lane   <= 2'd0;
                    r_tvalid <= 1'b1;
                    r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                    r_state  <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_hs) begin
                        r_remain <= r_remain - 16'd1;
                        if (w_last) begin
                            r_tvalid <= 1'b0;
                            r_state  <= S_REL;
                        end else if (r_lane == 2'd3) begin
                            r_word   <= r_rd_data;
                            r_lane   <= 2'd0;
                            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                        end else begin
                            r_word <= {8'h00, r_word[DATA_WIDTH-1:8]};
                            r_lane <= r_lane + 2'd1;
                        end
                    end
                end
                S_REL: begin
                    r_pkt_count <= r_pkt_count + 16'd1;
                    r_state     <= S_WAITLOW;
                end
                S_WAITLOW: begin
                    if (!udp_rxbuf_cpu_grant) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign udp_rxbuf_cpu_rel = (r_state == S_REL);
    assign m_axis_tdata      = r_word[7:0];
    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tlast      = w_last;
    assign rx_len            = r_rx_len;
    assign len_err           = r_len_err;
    assign pkt_count         = r_pkt_count;

endmodule

// File: tb/tb_udp_rxbuf_drain.sv
// Scoreboard bench for udp_rxbuf_drain: expected beats are queued when a packet
// is loaded and a negedge monitor pops them on every handshake.
module tb_udp_rxbuf_drain;

    logic        clk_int = 1'b0;
    logic        rst_int;
    logic [5:0]  udp_rxbuf_addr;
    logic        udp_rxbuf_ce;
    logic        udp_rxbuf_we;
    logic [31:0] udp_rxbuf_d;
    logic        udp_rxbuf_cpu_grant;
    logic        udp_rxbuf_cpu_rel;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [15:0] rx_len;
    logic        len_err;
    logic [15:0] pkt_count;

    always #5 clk_int = ~clk_int;

    udp_rxbuf_drain #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk_int             (clk_int),
        .rst_int             (rst_int),
        .udp_rxbuf_addr      (udp_rxbuf_addr),
        .udp_rxbuf_ce        (udp_rxbuf_ce),
        .udp_rxbuf_we        (udp_rxbuf_we),
        .udp_rxbuf_d         (udp_rxbuf_d),
        .udp_rxbuf_cpu_grant (udp_rxbuf_cpu_grant),
        .udp_rxbuf_cpu_rel   (udp_rxbuf_cpu_rel),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tlast        (m_axis_tlast),
        .rx_len              (rx_len),
        .len_err             (len_err),
        .pkt_count           (pkt_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      mon_b;
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         rel_cnt   = 0;
    int         beat_cnt  = 0;
    int         exp_pkt   = 0;
    logic       exp_err   = 1'b0;
    logic       rand_rdy  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk_int) begin
        if (rst_int) begin
            prev_stall = 1'b0;
        end else begin
            if (udp_rxbuf_cpu_rel) rel_cnt++;
            if (prev_stall) begin
                chk("stall_tvalid_held", 32'(m_axis_tvalid), 32'd1);
                chk("stall_tdata_held",  32'(m_axis_tdata), 32'(prev_data));
                chk("stall_tlast_held",  32'(m_axis_tlast), 32'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_tvalid", 32'(m_axis_tvalid), 32'd0);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("beat_tdata", 32'(m_axis_tdata), 32'(mon_b.data));
                    chk("beat_tlast", 32'(m_axis_tlast), 32'(mon_b.last));
                end
                beat_cnt++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_int);
        #1;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        udp_rxbuf_ce   = 1'b1;
        udp_rxbuf_we   = 1'b1;
        udp_rxbuf_addr = a;
        udp_rxbuf_d    = d;
        step();
        udp_rxbuf_ce   = 1'b0;
        udp_rxbuf_we   = 1'b0;
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
        return seed + 8'(i);
    endfunction

    function automatic int clampl(input logic [15:0] l);
        return (int'(l) > 252) ? 252 : int'(l);
    endfunction

    task automatic push_exp(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pat(seed, i), 1'(i == n - 1)});
        end
    endtask

    // Bytes past the length in the final word are filled with 0xEE so that any
    // over-read shows up as a wrong or unexpected beat.
    task automatic load_pkt(input logic [31:0] hdr, input logic [7:0] seed);
        int n;
        logic [31:0] w;
        n = clampl(hdr[15:0]);
        wr(6'd0, hdr);
        for (int k = 0; k < (n + 3) / 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                w[8*j +: 8] = (4*k + j < n) ? pat(seed, 4*k + j) : 8'hEE;
            end
            wr(6'(k + 1), w);
        end
        push_exp(n, seed);
    endtask

    task automatic run_drain(input int n, input int hold, input bit timed);
        int rel0;
        int rel_step;
        int first_tv;
        rel0     = rel_cnt;
        rel_step = 0;
        first_tv = 0;
        udp_rxbuf_cpu_grant = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            step();
            if (first_tv == 0 && m_axis_tvalid) first_tv = c;
            if (c == 3) chk("rx_len_after_E2", 32'(rx_len), 32'(n));
            if (udp_rxbuf_cpu_rel) begin
                rel_step = c;
                break;
            end
        end
        chk("rel_seen_in_budget", 32'(rel_step != 0), 32'd1);
        if (n == 0) chk("no_tvalid_for_L0", 32'(first_tv), 32'd0);
        else        chk("first_tvalid_cycle", 32'(first_tv), 32'd4);
        if (timed) chk("rel_cycle", 32'(rel_step), (n == 0) ? 32'd3 : 32'(4 + n));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_pkt++;
        for (int c = 0; c < hold; c++) begin
            step();
            chk("no_redrain_while_granted", 32'(m_axis_tvalid), 32'd0);
        end
        chk("rel_single_pulse", 32'(rel_cnt - rel0), 32'd1);
        chk("pkt_count", 32'(pkt_count), 32'(exp_pkt));
        chk("rx_len_final", 32'(rx_len), 32'(n));
        chk("len_err", 32'(len_err), 32'(exp_err));
        udp_rxbuf_cpu_grant = 1'b0;
        step();
        step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tvalid"},    32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tlast"},     32'(m_axis_tlast), 32'd0);
        chk({tag, "_tdata"},     32'(m_axis_tdata), 32'd0);
        chk({tag, "_rel"},       32'(udp_rxbuf_cpu_rel), 32'd0);
        chk({tag, "_rx_len"},    32'(rx_len), 32'd0);
        chk({tag, "_len_err"},   32'(len_err), 32'd0);
        chk({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    endtask

    initial begin
        int  b0;
        int  rel_before;
        bit  found;
        rst_int             = 1'b1;
        udp_rxbuf_addr      = 6'd0;
        udp_rxbuf_ce        = 1'b0;
        udp_rxbuf_we        = 1'b0;
        udp_rxbuf_d         = 32'd0;
        udp_rxbuf_cpu_grant = 1'b0;
        m_axis_tready       = 1'b1;
        step();
        step();
        step();
        chk_reset_vals("por");
        rst_int = 1'b0;
        step();

        // L=5, upper header bits set; grant held 3 cycles past release.
        load_pkt(32'hABCD_0005, 8'h01);
        run_drain(5, 3, 1'b1);

        // L=8 with random back-pressure.
        rand_rdy = 1'b1;
        load_pkt(32'h0000_0008, 8'h10);
        run_drain(8, 2, 1'b0);
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;

        // Empty packet.
        load_pkt(32'h0000_0000, 8'h00);
        run_drain(0, 2, 1'b1);

        // Oversized header clamps to 252 and sets the sticky error.
        exp_err = 1'b1;
        load_pkt(32'h0000_012C, 8'h01);
        run_drain(252, 2, 1'b1);

        // Reset after the third byte of a 20-byte drain with grant held.
        load_pkt(32'h0000_0014, 8'h40);
        b0         = beat_cnt;
        rel_before = rel_cnt;
        found      = 1'b0;
        udp_rxbuf_cpu_grant = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step();
            if (beat_cnt >= b0 + 3) begin
                found = 1'b1;
                break;
            end
        end
        chk("third_beat_seen", 32'(found), 32'd1);
        rst_int = 1'b1;
        step();
        chk_reset_vals("midrst");
        chk("no_rel_on_reset", 32'(rel_cnt - rel_before), 32'd0);
        exp_q.delete();
        exp_pkt = 0;
        exp_err = 1'b0;
        push_exp(20, 8'h40);
        rst_int = 1'b0;
        run_drain(20, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
